// File: rtl/imem_fetch_controller.sv
// Single-port instruction memory sequencer: program load, then in-order fetch
// into the IF/ID register with stall hold, redirect flush and error halt.
module imem_fetch_controller #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        halted,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

  localparam logic [31:0] LIMIT = 32'(DEPTH) << 2;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [1:0]  r_err;

  logic w_load_ok;
  logic w_in_load;

  assign w_in_load = (r_state == S_LOAD);
  assign w_load_ok = (load_addr[1:0] == 2'b00) && (load_addr < LIMIT);

  // Write enable is also gated by reset so the port is quiet while reset is held.
  assign load_ready  = w_in_load;
  assign halted      = (r_state == S_HALT);
  assign mem_we      = w_in_load && load_valid && w_load_ok && !reset;
  assign mem_addr    = w_in_load ? load_addr : r_pc;
  assign mem_wdata   = load_data;
  assign pc_out      = r_pc_out;
  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign err_code    = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_LOAD;
      r_pc     <= RESET_PC;
      r_pc_out <= 32'h0;
      r_instr  <= 32'h0;
      r_valid  <= 1'b0;
      r_err    <= 2'd0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_valid <= 1'b0;
          if (load_valid && !w_load_ok && r_err == 2'd0)
            r_err <= 2'd3;
          if (load_done) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
          end
        end
        S_RUN: begin
          if (load_start) begin
            r_state <= S_LOAD;
            r_valid <= 1'b0;
            r_err   <= 2'd0;
            r_pc    <= RESET_PC;
          end else if (redirect) begin
            r_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
              r_state <= S_HALT;
              if (r_err == 2'd0)
                r_err <= 2'd1;
            end else begin
              r_pc <= redirect_pc;
            end
          end else if (!stall) begin
            if (r_pc >= LIMIT) begin
              r_state <= S_HALT;
              r_valid <= 1'b0;
              if (r_err == 2'd0)
                r_err <= 2'd2;
            end else begin
              r_instr  <= mem_rdata;
              r_pc_out <= r_pc;
              r_valid  <= 1'b1;
              r_pc     <= r_pc + 32'd4;
            end
          end
        end
        S_HALT: begin
          r_valid <= 1'b0;
          if (load_start) begin
            r_state <= S_LOAD;
            r_err   <= 2'd0;
            r_pc    <= RESET_PC;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
